// File: rtl/mux_reg_arbiter.sv
// Two-requester arbiter that loads a shared WIDTH-bit register through a 2:1 select.
// Define MUX_REG_ARB_FIXED_PRIO_EN for fixed priority on ties; default is round-robin.
module mux_reg_arbiter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             req1,
    input  logic [WIDTH-1:0] d1,
    input  logic             req2,
    input  logic [WIDTH-1:0] d2,
    output logic             ack1,
    output logic             ack2,
    output logic [WIDTH-1:0] q,
    output logic             ctr,
    output logic             busy,
    output logic [7:0]       xfer_cnt
);

    typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             ctr_q, ctr_d;
    logic             ack1_q, ack1_d;
    logic             ack2_q, ack2_d;
    logic             busy_q, busy_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             tie_sel;

`ifdef MUX_REG_ARB_FIXED_PRIO_EN
    assign tie_sel = 1'b0;
`else
    logic last_sel_q, last_sel_d;

    // Round-robin: the tie goes to whoever did not win the previous tie.
    assign tie_sel = ~last_sel_q;
`endif

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        ctr_d   = ctr_q;
        ack1_d  = 1'b0;
        ack2_d  = 1'b0;
        cnt_d   = cnt_q;
`ifndef MUX_REG_ARB_FIXED_PRIO_EN
        last_sel_d = last_sel_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (req1 && req2) begin
                    ctr_d   = tie_sel;
                    state_d = StXfer;
`ifndef MUX_REG_ARB_FIXED_PRIO_EN
                    last_sel_d = tie_sel;
`endif
                end else if (req1) begin
                    ctr_d   = 1'b0;
                    state_d = StXfer;
                end else if (req2) begin
                    ctr_d   = 1'b1;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                q_d     = ctr_q ? d2 : d1;
                cnt_d   = cnt_q + 8'd1;
                ack1_d  = ~ctr_q;
                ack2_d  = ctr_q;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= StIdle;
            q_q     <= '0;
            ctr_q   <= 1'b0;
            ack1_q  <= 1'b0;
            ack2_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            ctr_q   <= ctr_d;
            ack1_q  <= ack1_d;
            ack2_q  <= ack2_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

`ifndef MUX_REG_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            last_sel_q <= 1'b1;
        end else begin
            last_sel_q <= last_sel_d;
        end
    end
`endif

    assign q        = q_q;
    assign ctr      = ctr_q;
    assign ack1     = ack1_q;
    assign ack2     = ack2_q;
    assign busy     = busy_q;
    assign xfer_cnt = cnt_q;

endmodule

// File: tb/tb_mux_reg_arbiter.sv
// Self-checking bench for mux_reg_arbiter: directed vector table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mux_reg_arbiter;

`ifdef MUX_REG_ARB_FIXED_PRIO_EN
    localparam bit Fixed = 1'b1;
`else
    localparam bit Fixed = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       req1 = 1'b0, req2 = 1'b0;
    logic [7:0] d1 = 8'h00, d2 = 8'h00;
    logic       ack1, ack2, ctr, busy;
    logic [7:0] q, xfer_cnt;

    int vectors = 0;
    int miscompares = 0;

    mux_reg_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .clear(clear),
        .req1(req1), .d1(d1), .req2(req2), .d2(d2),
        .ack1(ack1), .ack2(ack2), .q(q), .ctr(ctr), .busy(busy), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = waiting, 1 = granted, 2 = delivered.
    int         m_phase, m_win, m_last, m_cnt;
    logic [7:0] m_q;
    logic       m_ctr, m_ack1, m_ack2, m_busy;

    task automatic model_reset();
        m_phase = 0; m_win = 1; m_last = 2; m_cnt = 0;
        m_q = 8'h00; m_ctr = 1'b0; m_ack1 = 1'b0; m_ack2 = 1'b0; m_busy = 1'b0;
    endtask

    task automatic model_step();
        case (m_phase)
            0: begin
                if (req1 || req2) begin
                    if (req1 && req2) begin
                        m_win  = Fixed ? 1 : (m_last == 1 ? 2 : 1);
                        m_last = m_win;
                    end else begin
                        m_win = req1 ? 1 : 2;
                    end
                    m_ctr   = (m_win == 2);
                    m_phase = 1;
                end
            end
            1: begin
                m_q     = (m_win == 2) ? d2 : d1;
                m_cnt   = (m_cnt + 1) % 256;
                m_ack1  = (m_win == 1);
                m_ack2  = (m_win == 2);
                m_phase = 2;
            end
            default: begin
                m_ack1  = 1'b0;
                m_ack2  = 1'b0;
                m_phase = 0;
            end
        endcase
        m_busy = (m_phase != 0);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (clear) model_step();
        @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".q"}, q, m_q);
        chk({tag, ".ctr"}, ctr, m_ctr);
        chk({tag, ".ack1"}, ack1, m_ack1);
        chk({tag, ".ack2"}, ack2, m_ack2);
        chk({tag, ".busy"}, busy, m_busy);
        chk({tag, ".cnt"}, xfer_cnt, m_cnt);
        chk({tag, ".ack_excl"}, ack1 & ack2, 0);
    endtask

    task automatic do_reset();
        req1 = 1'b0; req2 = 1'b0;
        clear = 1'b0;
        model_reset();
        tick();
        tick();
        clear = 1'b1;
        chk_model("reset");
    endtask

    typedef struct {
        logic       r1, r2;
        logic [7:0] a, b;
        logic [7:0] eq;
        logic       eack1, eack2, ectr, ebusy;
        logic [7:0] ecnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [7:0] qa;
        qa = Fixed ? 8'h11 : 8'h22;
        tbl[0]  = '{1'b1, 1'b0, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        tbl[1]  = '{1'b1, 1'b0, 8'hA5, 8'h00, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[2]  = '{1'b0, 1'b0, 8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        tbl[4]  = '{1'b1, 1'b1, 8'h11, 8'h22, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1};
        tbl[5]  = '{1'b1, 1'b1, 8'h11, 8'h22, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
        tbl[6]  = '{1'b1, 1'b1, 8'h11, 8'h22, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
        tbl[7]  = '{1'b1, 1'b1, 8'h11, 8'h22, 8'h11, 1'b0, 1'b0, !Fixed, 1'b1, 8'd2};
        tbl[8]  = '{1'b1, 1'b1, 8'h11, 8'h22, qa, Fixed, !Fixed, !Fixed, 1'b1, 8'd3};
        tbl[9]  = '{1'b1, 1'b1, 8'h11, 8'h22, qa, 1'b0, 1'b0, !Fixed, 1'b0, 8'd3};
        tbl[10] = '{1'b1, 1'b1, 8'h11, 8'h22, qa, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3};
        tbl[11] = '{1'b1, 1'b1, 8'h11, 8'h22, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 8'd4};
        tbl[12] = '{1'b0, 1'b0, 8'h11, 8'h22, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4};

        @(negedge clk);
        do_reset();

        // Directed per-cycle table: single request, then held tie.
        for (int i = 0; i < 13; i++) begin
            req1 = tbl[i].r1; req2 = tbl[i].r2; d1 = tbl[i].a; d2 = tbl[i].b;
            tick();
            chk($sformatf("tbl%0d.q", i), q, tbl[i].eq);
            chk($sformatf("tbl%0d.ack1", i), ack1, tbl[i].eack1);
            chk($sformatf("tbl%0d.ack2", i), ack2, tbl[i].eack2);
            chk($sformatf("tbl%0d.ctr", i), ctr, tbl[i].ectr);
            chk($sformatf("tbl%0d.busy", i), busy, tbl[i].ebusy);
            chk($sformatf("tbl%0d.cnt", i), xfer_cnt, tbl[i].ecnt);
        end

        // Reset during XFER discards the transfer; held req2 is served afterwards.
        do_reset();
        req2 = 1'b1; d2 = 8'h5A;
        tick();
        chk("mid.busy_pre", busy, 1);
        chk("mid.ctr_pre", ctr, 1);
        clear = 1'b0;
        #1;
        chk("mid.q_rst", q, 8'h00);
        chk("mid.busy_rst", busy, 0);
        chk("mid.ctr_rst", ctr, 0);
        chk("mid.cnt_rst", xfer_cnt, 8'd0);
        tick();
        chk("mid.ack2_held", ack2, 0);
        chk("mid.q_held", q, 8'h00);
        clear = 1'b1;
        tick();
        chk("mid.busy_post", busy, 1);
        chk("mid.ack2_early", ack2, 0);
        tick();
        chk("mid.q_post", q, 8'h5A);
        chk("mid.ack2_post", ack2, 1);
        chk("mid.cnt_post", xfer_cnt, 8'd1);
        req2 = 1'b0;
        tick();

        // Counter wrap over 256 back-to-back single transfers.
        do_reset();
        req1 = 1'b1;
        for (int i = 1; i <= 256; i++) begin
            d1 = i[7:0] ^ 8'h3C;
            tick();
            tick();
            chk($sformatf("wrap%0d.cnt", i), xfer_cnt, i % 256);
            chk($sformatf("wrap%0d.q", i), q, i[7:0] ^ 8'h3C);
            tick();
        end
        req1 = 1'b0;

        // Randomized traffic with occasional asynchronous resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(63) == 0) begin
                clear = 1'b0;
                model_reset();
            end else begin
                clear = 1'b1;
            end
            req1 = ($urandom_range(3) != 0);
            req2 = ($urandom_range(2) != 0);
            d1 = 8'($urandom);
            d2 = 8'($urandom);
            tick();
            chk_model($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
